// File: rtl/ili9341_serial_sink_if.sv
// Signal bundle between an ILI9341 4-wire serial driver and the serial sink decoder.
// The slave modport is the display side; the master modport is the stream source.
interface ili9341_serial_sink_if;
  logic        spi_sck;
  logic        spi_cs;
  logic        spi_dc;
  logic        spi_din;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        pixel_valid;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic [15:0] pixel_rgb;
  logic        frame_done;
  logic        param_err;
  logic        frag_err;

  modport master (
    output spi_sck, spi_cs, spi_dc, spi_din,
    input  cmd_valid, cmd_byte, pixel_valid, pixel_x, pixel_y, pixel_rgb,
           frame_done, param_err, frag_err
  );

  modport slave (
    input  spi_sck, spi_cs, spi_dc, spi_din,
    output cmd_valid, cmd_byte, pixel_valid, pixel_x, pixel_y, pixel_rgb,
           frame_done, param_err, frag_err
  );
endinterface

// File: rtl/ili9341_serial_sink.sv
// ILI9341 serial stream decoder: oversampled byte assembly plus CASET/PASET/RAMWR
// interpretation, producing one pixel strobe per RGB565 word with window wrap.
module ili9341_serial_sink #(
  parameter int MAX_COL = 239,
  parameter int MAX_ROW = 319
) (
  input logic clk,
  input logic rst,
  ili9341_serial_sink_if.slave bus
);

  localparam logic [15:0] MAX_C = 16'(MAX_COL);
  localparam logic [15:0] MAX_R = 16'(MAX_ROW);

  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, IGNORE} state_t;

  // Input synchronizers and edge detect
  logic [1:0] sck_q, cs_q, dc_q, din_q;
  logic       sck_d;
  logic       sck_s, cs_s, dc_s, din_s;
  logic       sample;

  assign sck_s  = sck_q[1];
  assign cs_s   = cs_q[1];
  assign dc_s   = dc_q[1];
  assign din_s  = din_q[1];
  assign sample = sck_s & ~sck_d & ~cs_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_q <= '0;
      cs_q  <= '1;
      dc_q  <= '0;
      din_q <= '0;
      sck_d <= 1'b0;
    end else begin
      sck_q <= {sck_q[0], bus.spi_sck};
      cs_q  <= {cs_q[0],  bus.spi_cs};
      dc_q  <= {dc_q[0],  bus.spi_dc};
      din_q <= {din_q[0], bus.spi_din};
      sck_d <= sck_s;
    end
  end

  // Byte assembly
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic [7:0] byte_in;
  logic       byte_done;
  logic       byte_dc;
  logic       frag_q;

  assign byte_in   = {shift_q[6:0], din_s};
  assign byte_done = sample && (bit_cnt == 3'd7);
  assign byte_dc   = dc_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt <= '0;
      shift_q <= '0;
      frag_q  <= 1'b0;
    end else begin
      frag_q <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
        frag_q  <= (bit_cnt != 3'd0);
      end else if (sample) begin
        shift_q <= byte_in;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Command / window / pixel state
  state_t      state, state_n;
  logic [1:0]  pcnt, pcnt_n;
  logic [23:0] pbuf, pbuf_n;
  logic [15:0] sc, sc_n, ec, ec_n, sp, sp_n, ep, ep_n;
  logic [15:0] cur_x, cur_x_n, cur_y, cur_y_n;

  logic        cmd_valid_q, cmd_valid_n;
  logic [7:0]  cmd_byte_q, cmd_byte_n;
  logic        pix_valid_q, pix_valid_n;
  logic [15:0] pix_x_q, pix_x_n, pix_y_q, pix_y_n, pix_rgb_q, pix_rgb_n;
  logic        fd_q, fd_n;
  logic        perr_q, perr_n;

  logic [15:0] win_start, win_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pcnt        <= '0;
      pbuf        <= '0;
      sc          <= '0;
      ec          <= MAX_C;
      sp          <= '0;
      ep          <= MAX_R;
      cur_x       <= '0;
      cur_y       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_rgb_q   <= '0;
      fd_q        <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state       <= state_n;
      pcnt        <= pcnt_n;
      pbuf        <= pbuf_n;
      sc          <= sc_n;
      ec          <= ec_n;
      sp          <= sp_n;
      ep          <= ep_n;
      cur_x       <= cur_x_n;
      cur_y       <= cur_y_n;
      cmd_valid_q <= cmd_valid_n;
      cmd_byte_q  <= cmd_byte_n;
      pix_valid_q <= pix_valid_n;
      pix_x_q     <= pix_x_n;
      pix_y_q     <= pix_y_n;
      pix_rgb_q   <= pix_rgb_n;
      fd_q        <= fd_n;
      perr_q      <= perr_n;
    end
  end

  always_comb begin
    state_n     = state;
    pcnt_n      = pcnt;
    pbuf_n      = pbuf;
    sc_n        = sc;
    ec_n        = ec;
    sp_n        = sp;
    ep_n        = ep;
    cur_x_n     = cur_x;
    cur_y_n     = cur_y;
    cmd_valid_n = 1'b0;
    cmd_byte_n  = cmd_byte_q;
    pix_valid_n = 1'b0;
    pix_x_n     = pix_x_q;
    pix_y_n     = pix_y_q;
    pix_rgb_n   = pix_rgb_q;
    fd_n        = 1'b0;
    perr_n      = 1'b0;
    win_start   = pbuf[23:8];
    win_end     = {pbuf[7:0], byte_in};

    if (byte_done) begin
      if (!byte_dc) begin
        // A command always wins: pending parameter bytes or a half pixel are dropped.
        cmd_valid_n = 1'b1;
        cmd_byte_n  = byte_in;
        pcnt_n      = '0;
        case (byte_in)
          8'h2A: state_n = CASET;
          8'h2B: state_n = PASET;
          8'h2C: begin
            state_n = RAMWR;
            cur_x_n = sc;
            cur_y_n = sp;
          end
          default: state_n = IGNORE;
        endcase
      end else begin
        case (state)
          CASET, PASET: begin
            if (pcnt != 2'd3) begin
              pbuf_n = {pbuf[15:0], byte_in};
              pcnt_n = pcnt + 2'd1;
            end else begin
              pcnt_n  = '0;
              state_n = IGNORE;
              if (state == CASET) begin
                if (win_start <= win_end && win_end <= MAX_C) begin
                  sc_n = win_start;
                  ec_n = win_end;
                end else begin
                  perr_n = 1'b1;
                end
              end else begin
                if (win_start <= win_end && win_end <= MAX_R) begin
                  sp_n = win_start;
                  ep_n = win_end;
                end else begin
                  perr_n = 1'b1;
                end
              end
            end
          end
          RAMWR: begin
            if (pcnt == 2'd0) begin
              pbuf_n[7:0] = byte_in;
              pcnt_n      = 2'd1;
            end else begin
              pcnt_n      = '0;
              pix_valid_n = 1'b1;
              pix_x_n     = cur_x;
              pix_y_n     = cur_y;
              pix_rgb_n   = {pbuf[7:0], byte_in};
              fd_n        = (cur_x == ec) && (cur_y == ep);
              if (cur_x != ec) begin
                cur_x_n = cur_x + 16'd1;
              end else begin
                cur_x_n = sc;
                cur_y_n = (cur_y == ep) ? sp : cur_y + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_byte    = cmd_byte_q;
  assign bus.pixel_valid = pix_valid_q;
  assign bus.pixel_x     = pix_x_q;
  assign bus.pixel_y     = pix_y_q;
  assign bus.pixel_rgb   = pix_rgb_q;
  assign bus.frame_done  = fd_q;
  assign bus.param_err   = perr_q;
  assign bus.frag_err    = frag_q;

endmodule

// File: tb/tb_ili9341_serial_sink.sv
// Directed bench for ili9341_serial_sink: a byte table with per-byte expected events,
// plus hand sequences for fragments, long raster wrap and mid-byte reset.
module tb_ili9341_serial_sink;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ili9341_serial_sink_if bus ();

  ili9341_serial_sink #(
    .MAX_COL(239),
    .MAX_ROW(319)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_cmd = 0, n_pix = 0, n_fd = 0, n_perr = 0, n_frag = 0;
  logic [15:0] lx, ly, lrgb;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.cmd_valid)  n_cmd++;
      if (bus.frame_done) n_fd++;
      if (bus.param_err)  n_perr++;
      if (bus.frag_err)   n_frag++;
      if (bus.pixel_valid) begin
        n_pix++;
        lx   = bus.pixel_x;
        ly   = bus.pixel_y;
        lrgb = bus.pixel_rgb;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic dcv, input logic [7:0] b, input int nbits);
    bus.spi_cs = 1'b0;
    bus.spi_dc = dcv;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_din = b[7-i];
      tick(2);
      bus.spi_sck = 1'b1;
      tick(2);
      bus.spi_sck = 1'b0;
    end
  endtask

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    logic        ecmd;
    logic        epix;
    logic [15:0] ex, ey, ergb;
    logic        efd;
    logic        eperr;
  } vec_t;

  vec_t tbl[$];

  task automatic C(input logic [7:0] b);
    tbl.push_back('{1'b0, b, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0});
  endtask
  task automatic D(input logic [7:0] b);
    tbl.push_back('{1'b1, b, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0});
  endtask
  task automatic E(input logic [7:0] b);
    tbl.push_back('{1'b1, b, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1});
  endtask
  task automatic P(input logic [7:0] b, input logic [15:0] x, input logic [15:0] y,
                   input logic [15:0] rgb, input logic fd);
    tbl.push_back('{1'b1, b, 1'b0, 1'b1, x, y, rgb, fd, 1'b0});
  endtask

  logic [7:0] last_cmd = 8'h00;

  initial begin
    int c0, p0, f0, e0, q0;
    vec_t r;

    bus.spi_sck = 1'b0;
    bus.spi_cs  = 1'b1;
    bus.spi_dc  = 1'b0;
    bus.spi_din = 1'b0;

    // Reset to 2C then F800 at origin
    C(8'h2C); D(8'hF8); P(8'h00, 16'd0, 16'd0, 16'hF800, 1'b0);
    D(8'h12); P(8'h34, 16'd1, 16'd0, 16'h1234, 1'b0);
    // 2x2 window with wrap
    C(8'h2A); D(8'h00); D(8'h0A); D(8'h00); D(8'h0B);
    C(8'h2B); D(8'h00); D(8'h05); D(8'h00); D(8'h06);
    C(8'h2C);
    D(8'hAA); P(8'hBB, 16'd10, 16'd5, 16'hAABB, 1'b0);
    D(8'h00); P(8'h01, 16'd11, 16'd5, 16'h0001, 1'b0);
    D(8'h00); P(8'h02, 16'd10, 16'd6, 16'h0002, 1'b0);
    D(8'h00); P(8'h03, 16'd11, 16'd6, 16'h0003, 1'b1);
    D(8'h00); P(8'h04, 16'd10, 16'd5, 16'h0004, 1'b0);
    // Rejected windows keep the old one
    C(8'h2A); D(8'h00); D(8'h20); D(8'h00); E(8'h10);
    C(8'h2B); D(8'h00); D(8'h00); D(8'h01); E(8'h40);
    C(8'h2C); D(8'h07); P(8'hE0, 16'd10, 16'd5, 16'h07E0, 1'b0);
    // Half pixel cut by a command; short CASET does not commit
    D(8'h12); C(8'h2B);
    C(8'h2A); D(8'h00); D(8'h00); D(8'h00);
    // Unknown command swallows data
    C(8'h11); D(8'h01); D(8'h02); D(8'h03); D(8'h04);
    C(8'h2C); D(8'h55); P(8'h66, 16'd10, 16'd5, 16'h5566, 1'b0);
    // Window at the far corner; extra data after a committed CASET is ignored
    C(8'h2A); D(8'h00); D(8'hEE); D(8'h00); D(8'hEF); D(8'h99);
    C(8'h2B); D(8'h01); D(8'h3E); D(8'h01); D(8'h3F);
    C(8'h2C);
    D(8'hF8); P(8'h00, 16'd238, 16'd318, 16'hF800, 1'b0);
    D(8'hF8); P(8'h00, 16'd239, 16'd318, 16'hF800, 1'b0);
    D(8'hF8); P(8'h00, 16'd238, 16'd319, 16'hF800, 1'b0);
    D(8'hF8); P(8'h00, 16'd239, 16'd319, 16'hF800, 1'b1);
    D(8'hF8); P(8'h00, 16'd238, 16'd318, 16'hF800, 1'b0);
    // Full-screen window for the raster run below
    C(8'h2A); D(8'h00); D(8'h00); D(8'h00); D(8'hEF);
    C(8'h2B); D(8'h00); D(8'h00); D(8'h01); D(8'h3F);

    tick(5);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_cmd_byte", 32'(bus.cmd_byte), 32'd0);
    chk("rst_pixel", {bus.pixel_valid, bus.frame_done, bus.param_err, bus.frag_err}, 32'd0);
    chk("rst_xy", {bus.pixel_x, bus.pixel_y}, 32'd0);
    chk("rst_rgb", 32'(bus.pixel_rgb), 32'd0);
    rst = 1'b1;
    tick(4);

    foreach (tbl[i]) begin
      r  = tbl[i];
      c0 = n_cmd; p0 = n_pix; f0 = n_fd; e0 = n_perr;
      send_bits(r.dc, r.b, 8);
      tick(6);
      if (r.ecmd) last_cmd = r.b;
      chk($sformatf("row%0d_cmd_cnt", i), 32'(n_cmd - c0), 32'(r.ecmd));
      chk($sformatf("row%0d_cmd_byte", i), 32'(bus.cmd_byte), 32'(last_cmd));
      chk($sformatf("row%0d_pix_cnt", i), 32'(n_pix - p0), 32'(r.epix));
      chk($sformatf("row%0d_fd_cnt", i), 32'(n_fd - f0), 32'(r.epix & r.efd));
      chk($sformatf("row%0d_perr_cnt", i), 32'(n_perr - e0), 32'(r.eperr));
      if (r.epix) begin
        chk($sformatf("row%0d_x", i), 32'(lx), 32'(r.ex));
        chk($sformatf("row%0d_y", i), 32'(ly), 32'(r.ey));
        chk($sformatf("row%0d_rgb", i), 32'(lrgb), 32'(r.ergb));
      end
    end
    chk("no_frag_in_table", 32'(n_frag), 32'd0);

    // Fragment: five bits then cs high
    q0 = n_frag; c0 = n_cmd;
    send_bits(1'b0, 8'h2C, 5);
    bus.spi_cs = 1'b1;
    tick(8);
    chk("frag_err_cnt", 32'(n_frag - q0), 32'd1);
    chk("frag_no_cmd", 32'(n_cmd - c0), 32'd0);
    send_bits(1'b0, 8'h2C, 8);
    tick(6);
    chk("after_frag_cmd_cnt", 32'(n_cmd - c0), 32'd1);
    chk("after_frag_cmd_byte", 32'(bus.cmd_byte), 32'h2C);
    bus.spi_cs = 1'b1;
    tick(8);
    chk("clean_cs_no_frag", 32'(n_frag - q0), 32'd1);

    // Raster run across the first row boundary of the full window
    for (int i = 0; i < 241; i++) begin
      p0 = n_pix;
      send_bits(1'b1, 8'(i >> 8), 8);
      send_bits(1'b1, 8'(i), 8);
      tick(6);
      chk($sformatf("run%0d_cnt", i), 32'(n_pix - p0), 32'd1);
      chk($sformatf("run%0d_xy", i), {lx, ly}, {16'(i % 240), 16'(i / 240)});
    end
    chk("run_rgb_last", 32'(lrgb), 32'd240);

    // Narrow window, then reset mid-byte restores defaults
    send_bits(1'b0, 8'h2A, 8);
    send_bits(1'b1, 8'h00, 8); send_bits(1'b1, 8'h0A, 8);
    send_bits(1'b1, 8'h00, 8); send_bits(1'b1, 8'h0B, 8);
    send_bits(1'b0, 8'h2C, 8);
    send_bits(1'b1, 8'h12, 3);
    rst = 1'b0;
    bus.spi_cs = 1'b1;
    tick(2);
    chk("midrst_cmd_byte", 32'(bus.cmd_byte), 32'd0);
    chk("midrst_xy", {bus.pixel_x, bus.pixel_y}, 32'd0);
    chk("midrst_rgb", 32'(bus.pixel_rgb), 32'd0);
    rst = 1'b1;
    tick(4);
    q0 = n_frag; p0 = n_pix;
    send_bits(1'b0, 8'h2C, 8);
    send_bits(1'b1, 8'hAB, 8);
    send_bits(1'b1, 8'hCD, 8);
    send_bits(1'b1, 8'h01, 8);
    send_bits(1'b1, 8'h02, 8);
    tick(6);
    chk("midrst_pix_cnt", 32'(n_pix - p0), 32'd2);
    chk("midrst_last_xy", {lx, ly}, {16'd1, 16'd0});
    chk("midrst_last_rgb", 32'(lrgb), 32'h0102);
    chk("midrst_no_frag", 32'(n_frag - q0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ili9341_serial_sink.md
Name: ili9341_serial_sink

Overview:
- Display-side decoder for the ILI9341 4-wire serial stream (cs, dc, din, serial clock) that our raster/driver blocks generate.
- Oversamples the serial lines on the system clock and assembles bytes MSB-first.
- Interprets CASET (0x2A), PASET (0x2B) and RAMWR (0x2C), then emits one pixel-write strobe per RGB565 word, with its column/page address and window wrap.
- Serves as the bench display model and as a loopback checker in hardware.

Parameters:
- MAX_COL, 239, highest legal column address.
- MAX_ROW, 319, highest legal page address.

Ports:
- clk  in  1  system clock; must be at least 4x the serial clock frequency.
- rst  in  1  reset; synchronous, active-low.
- spi_sck  in  1  serial clock from the driver; asynchronous to clk.
- spi_cs  in  1  chip select, active low.
- spi_dc  in  1  0 = command byte, 1 = parameter/data byte.
- spi_din  in  1  serial data; stable around each spi_sck rising edge.
- cmd_valid  out  1  one-cycle pulse when a command byte completes.
- cmd_byte  out  8  last command byte; held until the next command.
- pixel_valid  out  1  one-cycle pulse per completed pixel.
- pixel_x  out  16  column of the pixel.
- pixel_y  out  16  page of the pixel.
- pixel_rgb  out  16  RRRRRGGGGGGBBBBB.
- frame_done  out  1  one-cycle pulse with the pixel at (end col, end page).
- param_err  out  1  one-cycle pulse when an address window is rejected.
- frag_err  out  1  one-cycle pulse when cs rises with 1..7 bits pending.

Behaviour:
- Input sampling
  - spi_sck, spi_cs, spi_dc and spi_din each pass through a 2-flop synchronizer.
  - sck_rise = synced sck high and previous synced sck low.
  - A bit is sampled only on a cycle where sck_rise=1 and synced cs=0. Call this the sample cycle.
- Byte assembly
  - 8-bit shift register, MSB first, with a 3-bit counter.
  - On the 8th sample, the byte and the dc value sampled with that 8th bit are handed to the FSM in the same cycle; the counter returns to 0.
- cs high
  - Synced cs=1 clears the counter.
  - If the counter was 1..7, frag_err pulses and the partial byte is discarded.
  - FSM state is kept across cs-high gaps.
  - cs rising in the same cycle as the 8th sample: the byte still completes.
- Window registers and reset values
  - sc=0, ec=MAX_COL, sp=0, ep=MAX_ROW.
  - cur_x=0, cur_y=0.
  - FSM=IDLE.
  - All outputs 0.
- FSM states: IDLE, CASET, PASET, RAMWR, IGNORE.
- Any command byte (dc=0), in any state:
  - cmd_valid pulses next cycle; cmd_byte updates.
  - Any partial parameter or pixel is discarded.
  - Next state: 0x2A -> CASET, 0x2B -> PASET, 0x2C -> RAMWR, any other value -> IGNORE.
  - On entry to RAMWR, cur_x<=sc and cur_y<=sp.
- CASET / PASET
  - Collect 4 data bytes: start[15:8], start[7:0], end[15:8], end[7:0].
  - On the 4th byte, commit if start<=end and end<=MAX (MAX_COL or MAX_ROW respectively). Otherwise keep the old values and pulse param_err.
  - Then go to IGNORE. Further data bytes are ignored until the next command.
  - Fewer than 4 bytes before the next command: no commit, no error.
- RAMWR
  - Data bytes pair up as high byte then low byte.
  - On the low byte, pixel_valid pulses 1 cycle after that sample cycle, with pixel_x=cur_x, pixel_y=cur_y and pixel_rgb={hi,lo}.
  - Address advance:
    - If cur_x != ec: cur_x+1.
    - Otherwise cur_x<=sc, and cur_y becomes cur_y+1, or sp if cur_y==ep.
  - frame_done pulses alongside the pixel at (ec,ep). The stream then continues from (sc,sp) indefinitely.
- IDLE / IGNORE: data bytes are dropped.
- Reset asserted mid-byte or mid-pixel returns everything to reset values on the next clk edge.

Test Plan:
- Reset, then 0x2C followed by data F8 00 -> pixel_valid with x=0, y=0, rgb=0xF800; cmd_byte=0x2C.
- 0x2A + 00 00 00 EF, 0x2B + 00 00 01 3F, 0x2C, then 76800 pixels of 0xF800 -> last pixel x=239, y=319 with frame_done=1; next pixel x=0, y=0.
- Window 2A: 00 0A 00 0B and 2B: 00 05 00 06, then 0x2C + 5 pixels -> (10,5), (11,5), (10,6), (11,6), (10,5); frame_done on the 4th pixel.
- 2A: 00 20 00 10 (start>end) -> param_err pulse; sc=0 and ec=239 unchanged. Likewise 2B with end=0x0140 -> param_err.
- cs rising after 5 bits -> frag_err pulse. The next full byte decodes correctly.
- During RAMWR, a high byte followed by command 0x2B -> no pixel_valid; cmd_valid with 0x2B. Also: unknown command 0x11 with data bytes -> no pixel or window change.
